param_ram: RTL

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram.sv | 123 ++++++++++++
 1 files changed

// File: rtl/param_ram.sv
// Parameterised single-port RAM with byte enables, a pattern-init sweep
// and a pipelined read path of 1 or 2 cycles.
module param_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_sweep;
  logic                r_ready;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_dout;
  logic                r_rvalid;

  logic                w_acc;
  logic                w_rd;
  logic                w_wr;
  logic [DATA_W-1:0]   w_init_word;
  logic [DATA_W-1:0]   w_rdata;

  assign w_acc   = cen & r_ready & ~clr;
  assign w_rd    = w_acc & ~wen;
  assign w_wr    = w_acc & wen;
  assign w_rdata = r_mem[addr];

  assign w_init_word = (INIT_MODE == 1)
                     ? (DATA_W'(1) << (int'(r_sweep) % DATA_W))
                     : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_sweep <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        INIT: begin
          if (&r_sweep) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        RUN: begin
          if (clr) begin
            r_state <= INIT;
            r_sweep <= '0;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is never reset; the sweep alone defines its contents.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_sweep] <= w_init_word;
    end else if (w_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) r_mem[addr][8*k +: 8] <= din[8*k +: 8];
      end
    end
  end

  // Data is captured at acceptance, so in-flight reads survive a clear.
  if (RD_LAT == 2) begin : g_lat2
    logic              r_v1;
    logic [DATA_W-1:0] r_d1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v1     <= 1'b0;
        r_d1     <= '0;
        r_rvalid <= 1'b0;
        r_dout   <= '0;
      end else begin
        r_v1     <= w_rd;
        r_d1     <= w_rd ? w_rdata : '0;
        r_rvalid <= r_v1;
        r_dout   <= r_d1;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rvalid <= 1'b0;
        r_dout   <= '0;
      end else begin
        r_rvalid <= w_rd;
        r_dout   <= w_rd ? w_rdata : '0;
      end
    end
  end

  assign dout   = r_dout;
  assign rvalid = r_rvalid;
  assign ready  = r_ready;

endmodule
